// File: rtl/score_bcd_keeper.sv
// Four-digit BCD score and high-score keeper for the game display.
// The score saturates at 9999. A new high score is latched on game_over and makes the current-score view blink.
module score_bcd_keeper #(
  parameter int BLINK_BIT = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_valid,
  input  logic [3:0] add_amt,
  input  logic       game_over,
  input  logic       show_high,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       digit_blank,
  output logic       saturated,
  output logic       new_high,
  output logic       bad_amt
);

  // Strobe semantics: add_valid, clr and game_over are single-cycle pulses with no
  // ready/back-pressure; each is consumed on the rising edge where it is high.

  logic [15:0]        score;
  logic [15:0]        high;
  logic [BLINK_BIT:0] blink_cnt;

  logic [15:0] add_sum;
  logic        add_carry;
  logic [4:0]  dsum;
  logic        amt_ok;
  logic        do_add;
  logic        beat_high;

  assign amt_ok    = (add_amt <= 4'd9);
  assign do_add    = add_valid & amt_ok;
  // Valid BCD digits order the same way as their binary concatenation.
  assign beat_high = game_over & (score > high);

  // BCD ripple add of add_amt into the units digit.
  always_comb begin
    add_sum   = score;
    add_carry = 1'b0;
    dsum      = 5'd0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, score[4*i +: 4]} + {1'b0, ((i == 0) ? add_amt : 4'd0)} + {4'd0, add_carry};
      if (dsum > 5'd9) begin
        add_sum[4*i +: 4] = 4'(dsum - 5'd10);
        add_carry         = 1'b1;
      end else begin
        add_sum[4*i +: 4] = dsum[3:0];
        add_carry         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score     <= 16'h0000;
      saturated <= 1'b0;
    end else if (clr) begin
      score     <= 16'h0000;
      saturated <= 1'b0;
    end else if (do_add) begin
      if (add_carry) begin
        score     <= 16'h9999;
        saturated <= 1'b1;
      end else begin
        score <= add_sum;
      end
    end
  end

  // The compare always sees the score from before this edge, so a same-cycle add or clear does not affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high     <= 16'h0000;
      new_high <= 1'b0;
    end else begin
      if (beat_high) begin
        high     <= score;
        new_high <= 1'b1;
      end else if (clr) begin
        new_high <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_amt <= 1'b0;
    end else if (add_valid && !amt_ok) begin
      bad_amt <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    {digit3, digit2, digit1, digit0} = show_high ? high : score;
  end

  assign digit_blank = new_high & blink_cnt[BLINK_BIT] & ~show_high;

endmodule

// File: tb/tb_score_bcd_keeper.sv
// Directed bench for score_bcd_keeper with hand-computed expected values.
module tb_score_bcd_keeper;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       add_valid;
  logic [3:0] add_amt;
  logic       game_over;
  logic       show_high;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       digit_blank;
  logic       saturated;
  logic       new_high;
  logic       bad_amt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  score_bcd_keeper #(.BLINK_BIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .add_valid   (add_valid),
    .add_amt     (add_amt),
    .game_over   (game_over),
    .show_high   (show_high),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .digit_blank (digit_blank),
    .saturated   (saturated),
    .new_high    (new_high),
    .bad_amt     (bad_amt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count since reset release; bit 2 is the expected blink phase.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] amt);
    add_valid = 1'b1;
    add_amt   = amt;
    tick();
    add_valid = 1'b0;
    add_amt   = 4'd0;
  endtask

  task automatic add_n(input int n, input logic [3:0] amt);
    for (int i = 0; i < n; i++) add(amt);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse_go();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; add_valid = 1'b0; add_amt = 4'd0;
    game_over = 1'b0; show_high = 1'b0;
    tick();
    check("rst_digits", 32'(digits()), 32'h0000);
    check("rst_flags", {29'd0, saturated, new_high, bad_amt}, 32'd0);
    check("rst_blank", 32'(digit_blank), 32'd0);
    rst = 1'b0;
    tick();

    // three adds of 9 -> 0027
    add_n(3, 4'd9);
    check("add27", 32'(digits()), 32'h0027);
    check("add27_sat", 32'(saturated), 32'd0);
    add(4'd0);
    check("add_zero", 32'(digits()), 32'h0027);

    // 0123 vs high 0000
    pulse_clr();
    check("clr_score", 32'(digits()), 32'h0000);
    add_n(13, 4'd9);
    add(4'd6);
    check("score123", 32'(digits()), 32'h0123);
    pulse_go();
    check("go_new_high", 32'(new_high), 32'd1);
    show_high = 1'b1;
    #1;
    check("high123", 32'(digits()), 32'h0123);
    show_high = 1'b0;
    pulse_go();
    check("go_equal_nh", 32'(new_high), 32'd1);
    show_high = 1'b1;
    #1;
    check("high123_again", 32'(digits()), 32'h0123);
    show_high = 1'b0;

    // high 0040, then game_over + add 5 at score 0050
    do_reset();
    check("rst_high", {16'd0, digits()}, 32'h0000);
    add_n(4, 4'd9);
    add(4'd4);
    pulse_go();
    pulse_clr();
    check("clr_nh", 32'(new_high), 32'd0);
    add_n(5, 4'd9);
    add(4'd5);
    check("score50", 32'(digits()), 32'h0050);
    game_over = 1'b1;
    add(4'd5);
    game_over = 1'b0;
    check("go_add_score", 32'(digits()), 32'h0055);
    check("go_add_nh", 32'(new_high), 32'd1);
    show_high = 1'b1;
    #1;
    check("go_add_high", 32'(digits()), 32'h0050);
    show_high = 1'b0;

    // game_over + clr: latch 0055, score clears, new_high stays set
    game_over = 1'b1;
    clr = 1'b1;
    tick();
    game_over = 1'b0;
    clr = 1'b0;
    check("go_clr_score", 32'(digits()), 32'h0000);
    check("go_clr_nh", 32'(new_high), 32'd1);
    show_high = 1'b1;
    #1;
    check("go_clr_high", 32'(digits()), 32'h0055);
    show_high = 1'b0;
    pulse_clr();
    add_n(6, 4'd9);
    add(4'd1);
    pulse_go();
    check("equal_no_nh", 32'(new_high), 32'd0);

    // saturation
    pulse_clr();
    add_n(1110, 4'd9);
    add(4'd5);
    check("score9995", 32'(digits()), 32'h9995);
    check("sat_before", 32'(saturated), 32'd0);
    add(4'd7);
    check("sat_score", 32'(digits()), 32'h9999);
    check("sat_flag", 32'(saturated), 32'd1);
    add(4'd1);
    check("sat_hold", 32'(digits()), 32'h9999);
    check("sat_hold_flag", 32'(saturated), 32'd1);
    clr = 1'b1;
    add(4'd3);
    clr = 1'b0;
    check("clr_over_add", 32'(digits()), 32'h0000);
    check("clr_sat", 32'(saturated), 32'd0);

    // illegal amount
    add(4'd3);
    add(4'd12);
    check("bad_score", 32'(digits()), 32'h0003);
    check("bad_flag", 32'(bad_amt), 32'd1);
    pulse_clr();
    check("bad_after_clr", 32'(bad_amt), 32'd1);
    do_reset();
    check("bad_after_rst", 32'(bad_amt), 32'd0);

    // blink: set new_high, then follow the 8-cycle pattern
    add(4'd1);
    pulse_go();
    check("blink_nh", 32'(new_high), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("blink", 32'(digit_blank), 32'((cyc >> 2) & 1));
      tick();
    end
    show_high = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("blink_high_view", 32'(digit_blank), 32'd0);
      tick();
    end
    show_high = 1'b0;
    begin
      int budget = 16;
      while (!((cyc >> 2) & 1) && budget > 0) begin
        tick();
        budget--;
      end
      check("blink_wait", 32'(budget > 0), 32'd1);
    end
    check("blink_on", 32'(digit_blank), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_blank_async", 32'(digit_blank), 32'd0);
    check("rst_digits_async", 32'(digits()), 32'h0000);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
